// File: rtl/egr_wadj_cfg_init.sv
// Programs the egress width-adjust CTRL/THRESH CSRs over AVMM, reads both back,
// and flags any mismatch or read timeout in a sticky error code.
module egr_wadj_cfg_init #(
    parameter int unsigned BASE_ADDR  = 32'h0,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    cfg_drop_en_in,
    input  logic [15:0]             cfg_drop_threshold_in,
    output logic [ADDR_WIDTH-1:0]   avmm_address,
    output logic                    avmm_read,
    output logic                    avmm_write,
    output logic [DATA_WIDTH-1:0]   avmm_writedata,
    output logic [DATA_WIDTH/8-1:0] avmm_byteenable,
    input  logic [DATA_WIDTH-1:0]   avmm_readdata,
    input  logic                    avmm_readdata_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [2:0]              err_code
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned THR_W = 16;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] THR_ADDR  = ADDR_WIDTH'(BASE_ADDR + 32'd4);
    localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(TIMEOUT);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WR_CTRL   = 3'd1;
    localparam logic [2:0] WR_THR    = 3'd2;
    localparam logic [2:0] RD_CTRL   = 3'd3;
    localparam logic [2:0] WAIT_CTRL = 3'd4;
    localparam logic [2:0] RD_THR    = 3'd5;
    localparam logic [2:0] WAIT_THR  = 3'd6;
    localparam logic [2:0] DONE      = 3'd7;

    logic [2:0]            state_q,    state_d;
    logic                  drop_en_q,  drop_en_d;
    logic [THR_W-1:0]      thr_q,      thr_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [2:0]            err_code_q, err_code_d;
    logic                  err_q,      err_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;
    logic                  read_q,     read_d;
    logic                  write_q,    write_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic [BE_W-1:0]       be_q,       be_d;

    // Only the low 16 bits of read data are ever compared.
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^avmm_readdata[DATA_WIDTH-1:THR_W];

    // Next-state, latched config, wait counter and error accumulation.
    always_comb begin
        state_d    = state_q;
        drop_en_d  = drop_en_q;
        thr_d      = thr_q;
        cnt_d      = cnt_q;
        err_code_d = err_code_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    drop_en_d  = cfg_drop_en_in;
                    thr_d      = cfg_drop_threshold_in;
                    err_code_d = 3'b000;
                    state_d    = WR_CTRL;
                end
            end
            WR_CTRL: state_d = WR_THR;
            WR_THR:  state_d = RD_CTRL;
            RD_CTRL: begin
                cnt_d   = '0;
                state_d = WAIT_CTRL;
            end
            WAIT_CTRL: begin
                if (avmm_readdata_valid) begin
                    if (avmm_readdata[0] != drop_en_q) err_code_d[0] = 1'b1;
                    state_d = RD_THR;
                end else if (cnt_q == CNT_MAX) begin
                    err_code_d[2] = 1'b1;
                    state_d       = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_THR: begin
                cnt_d   = '0;
                state_d = WAIT_THR;
            end
            WAIT_THR: begin
                if (avmm_readdata_valid) begin
                    if (avmm_readdata[THR_W-1:0] != thr_q) err_code_d[1] = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CNT_MAX) begin
                    err_code_d[2] = 1'b1;
                    state_d       = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus strobes and status decoded from the next state so they register in step with it.
    always_comb begin
        read_d  = 1'b0;
        write_d = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        be_d    = '0;
        case (state_d)
            WR_CTRL: begin
                write_d = 1'b1;
                addr_d  = CTRL_ADDR;
                wdata_d = DATA_WIDTH'(drop_en_d);
                be_d    = BE_W'(4'b0001);
            end
            WR_THR: begin
                write_d = 1'b1;
                addr_d  = THR_ADDR;
                wdata_d = DATA_WIDTH'(thr_d);
                be_d    = BE_W'(4'b0011);
            end
            RD_CTRL: begin
                read_d = 1'b1;
                addr_d = CTRL_ADDR;
                be_d   = '1;
            end
            RD_THR: begin
                read_d = 1'b1;
                addr_d = THR_ADDR;
                be_d   = '1;
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        err_d  = |err_code_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            drop_en_q  <= 1'b0;
            thr_q      <= '0;
            cnt_q      <= '0;
            err_code_q <= 3'b000;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else begin
            state_q    <= state_d;
            drop_en_q  <= drop_en_d;
            thr_q      <= thr_d;
            cnt_q      <= cnt_d;
            err_code_q <= err_code_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            read_q     <= read_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
        end
    end

    assign avmm_address    = addr_q;
    assign avmm_read       = read_q;
    assign avmm_write      = write_q;
    assign avmm_writedata  = wdata_q;
    assign avmm_byteenable = be_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign err_code        = err_code_q;

endmodule

// File: tb/tb_egr_wadj_cfg_init.sv
// Scoreboarded bench for egr_wadj_cfg_init: a sequence-level model predicts every
// bus strobe and the completion, and a monitor compares whatever the DUT presents.
module tb_egr_wadj_cfg_init;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cfg_drop_en_in = 1'b0;
    logic [15:0] cfg_drop_threshold_in = 16'h0;
    logic [7:0]  avmm_address;
    logic        avmm_read;
    logic        avmm_write;
    logic [31:0] avmm_writedata;
    logic [3:0]  avmm_byteenable;
    logic [31:0] avmm_readdata = 32'h0;
    logic        avmm_readdata_valid = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  err_code;

    always #5 clk = ~clk;

    egr_wadj_cfg_init dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start                 (start),
        .cfg_drop_en_in        (cfg_drop_en_in),
        .cfg_drop_threshold_in (cfg_drop_threshold_in),
        .avmm_address          (avmm_address),
        .avmm_read             (avmm_read),
        .avmm_write            (avmm_write),
        .avmm_writedata        (avmm_writedata),
        .avmm_byteenable       (avmm_byteenable),
        .avmm_readdata         (avmm_readdata),
        .avmm_readdata_valid   (avmm_readdata_valid),
        .busy                  (busy),
        .done                  (done),
        .err                   (err),
        .err_code              (err_code)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = write, 1 = read, 2 = done (data holds err_code)
    typedef struct {
        int kind;
        int addr;
        int data;
        int be;
        int at;
    } ev_t;
    ev_t sb[$];

    // Responder settings for the current sequence (latency 0 = never answer).
    int          r_lc = 1;
    int          r_lt = 1;
    logic [31:0] r_cdata = 32'h0;
    logic [31:0] r_tdata = 32'h0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_ev(input int kind, input int addr, input int data,
                                    input int be, input int at);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.be = be; e.at = at;
        sb.push_back(e);
    endfunction

    // Monitor: pops an expectation whenever the DUT strobes or signals done.
    initial begin
        logic rst_s;
        int   hold;
        ev_t  e;
        hold = 0;
        forever begin
            @(posedge clk);
            rst_s = rst_n;
            #1;
            if (!rst_s) begin
                chk("rst_read", avmm_read, 0);
                chk("rst_write", avmm_write, 0);
                chk("rst_addr", avmm_address, 0);
                chk("rst_wdata", avmm_writedata, 0);
                chk("rst_be", avmm_byteenable, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_err", {err, err_code}, 0);
                hold = 0;
            end else begin
                chk("rw_exclusive", avmm_read & avmm_write, 0);
                if (avmm_read || avmm_write) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_strobe", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("strobe_kind", avmm_write ? 0 : 1, e.kind);
                        chk("strobe_addr", avmm_address, e.addr);
                        chk("strobe_be", avmm_byteenable, e.be);
                        chk("strobe_cycle", cyc, e.at);
                        if (avmm_write) begin
                            chk("write_data", avmm_writedata, e.data);
                            chk("err_cleared", {err, err_code}, 0);
                        end else begin
                            chk("read_wdata_zero", avmm_writedata, 0);
                        end
                    end
                end else begin
                    chk("idle_addr", avmm_address, 0);
                    chk("idle_wdata", avmm_writedata, 0);
                    chk("idle_be", avmm_byteenable, 0);
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_kind", 2, e.kind);
                        chk("done_cycle", cyc, e.at);
                        chk("done_err_code", err_code, e.data);
                        chk("done_err", err, (e.data != 0) ? 1 : 0);
                        chk("done_busy", busy, 1);
                        hold = e.data;
                    end
                end else if (!busy) begin
                    chk("err_hold", {err, err_code}, {(hold != 0) ? 1'b1 : 1'b0, 3'(hold)});
                end
            end
        end
    end

    // Responder: answers reads after the configured latency, plus stray valids
    // in cycles where the DUT is not waiting for read data.
    initial begin
        logic        r_rst;
        int          pend;
        logic [31:0] pend_data;
        pend = 0;
        pend_data = 32'h0;
        forever begin
            @(posedge clk);
            r_rst = rst_n;
            #1;
            avmm_readdata_valid = 1'b0;
            avmm_readdata = $urandom;
            if (!r_rst) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        avmm_readdata_valid = 1'b1;
                        avmm_readdata = pend_data;
                    end
                end
                if (avmm_read) begin
                    pend = (avmm_address == 8'h0) ? r_lc : r_lt;
                    pend_data = (avmm_address == 8'h0) ? r_cdata : r_tdata;
                end else if (!avmm_readdata_valid && (!busy || avmm_write)
                             && $urandom_range(0, 3) == 0) begin
                    avmm_readdata_valid = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One program/verify sequence. Expected strobes and completion are derived from
    // the sequence-level timing: writes 1 and 2 cycles after start, CTRL read at 3,
    // each read answered L cycles later, and a read that is not answered within 256
    // wait cycles ends the sequence as if answered at the last permitted cycle.
    task automatic run_seq(input bit en, input logic [15:0] thr, input int lc, input int lt,
                           input bit cbad, input logic [15:0] tmask,
                           input bit restart, input int rst_at);
        int          s;
        int          code;
        int          dcyc;
        logic [31:0] rnd;
        rnd = $urandom;
        r_cdata = {rnd[31:1], en ^ cbad};
        rnd = $urandom;
        r_tdata = {rnd[31:16], thr ^ tmask};
        r_lc = lc;
        r_lt = lt;
        s = cyc;
        push_ev(0, 'h0, int'(en), 'h1, s + 1);
        push_ev(0, 'h4, int'(thr), 'h3, s + 2);
        push_ev(1, 'h0, 0, 'hf, s + 3);
        if (lc == 0 || lc > 256) begin
            code = 4;
            dcyc = s + 260;
        end else begin
            code = cbad ? 1 : 0;
            push_ev(1, 'h4, 0, 'hf, s + 4 + lc);
            if (lt == 0 || lt > 256) begin
                code = code | 4;
                dcyc = s + 5 + lc + 256;
            end else begin
                code = code | ((tmask != 16'h0) ? 2 : 0);
                dcyc = s + 5 + lc + lt;
            end
        end
        push_ev(2, 0, code, 0, dcyc);

        cfg_drop_en_in = en;
        cfg_drop_threshold_in = thr;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_drop_en_in = 1'($urandom);
        cfg_drop_threshold_in = 16'($urandom);
        if (restart) begin
            idle(2);
            cfg_drop_en_in = ~en;
            cfg_drop_threshold_in = ~thr;
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        if (rst_at > 0) begin
            while (cyc < s + rst_at) tick();
            rst_n = 1'b0;
            tick();
            sb.delete();
            tick();
            rst_n = 1'b1;
            return;
        end
        for (int i = 0; i < 400 && sb.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            chk("seq_complete", sb.size(), 0);
            sb.delete();
        end
        tick();
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        tick();
        // Nominal: echo responder at latency 1.
        run_seq(1'b1, 16'h1234, 1, 1, 1'b0, 16'h0, 1'b0, 0);
        idle(2);
        // THRESH readback 0x1235, then verify the error holds while idle.
        run_seq(1'b1, 16'h1234, 1, 1, 1'b0, 16'h0001, 1'b0, 0);
        idle(6);
        // CTRL read never answered: timeout, no THRESH read.
        run_seq(1'b0, 16'hbeef, 0, 1, 1'b0, 16'h0, 1'b0, 0);
        idle(3);
        // Start re-pulsed mid-sequence with different inputs is ignored.
        run_seq(1'b1, 16'h00a5, 2, 1, 1'b0, 16'h0, 1'b1, 0);
        idle(1);
        // Valid on the final permitted wait cycle is data, not timeout.
        run_seq(1'b0, 16'h7fff, 256, 3, 1'b1, 16'h0, 1'b0, 0);
        idle(2);
        // THRESH read times out after a CTRL mismatch.
        run_seq(1'b1, 16'h0f0f, 2, 0, 1'b1, 16'h0, 1'b0, 0);
        idle(2);
        // Reset while waiting on THRESH, then a start on the first cycle after release.
        run_seq(1'b1, 16'h4321, 1, 0, 1'b0, 16'h0, 1'b0, 9);
        run_seq(1'b0, 16'hffff, 1, 1, 1'b0, 16'h0, 1'b0, 0);
        idle(2);
        for (int i = 0; i < 16; i++) begin
            bit          en;
            logic [15:0] thr;
            logic [15:0] tm;
            en  = 1'($urandom);
            thr = 16'($urandom);
            tm  = ($urandom_range(0, 3) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
            run_seq(en, thr, $urandom_range(1, 4), $urandom_range(1, 5),
                    ($urandom_range(0, 3) == 0), tm, ($urandom_range(0, 4) == 0), 0);
            idle($urandom_range(0, 3));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
